irrigation_sequencer: RTL and testbench
=======================================

// Module: irrigation_sequencer
// PURPOSE
//  Downstream of irrigation_state: consumes its 3-bit irrigation type code and runs one timed
//  irrigation cycle, driving sprinkler and drip valves. Counts tick-enable pulses for durations,
//  aborts on loss of water, and re-arms only after the soil-wet code (000) returns.
// PARAMETERS
//  SPRINKLE_TICKS  1350  sprinkler-phase duration in ticks (22:30 min at 1 tick/s); >=1
//  DRIP_TICKS      1800  drip-phase duration in ticks; >=1
//  CNT_W           12    tick-counter width; must hold max(SPRINKLE_TICKS,DRIP_TICKS)-1
// PORTS
//  clk             in   1      system clock, all flops rising edge
//  rst_n           in   1      asynchronous active-low reset
//  tick            in   1      1-cycle time-base enable pulse
//  irr_type        in   3      001 sprinkle->drip, 010 drip, 100 sprinkle, 000 none
//  water_ok        in   1      1 = reservoir level sufficient
//  sprinkler_valve out  1      registered, 1 = sprinkler open
//  drip_valve      out  1      registered, 1 = drip open
//  busy            out  1      registered, 1 in SPRINKLE or DRIP
//  done            out  1      registered 1-cycle pulse on normal completion
//  fault           out  1      registered, 1 in ABORT (water lost mid-cycle)
//  bad_code        out  1      registered, 1 while in IDLE with irr_type in {011,101,110,111}
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, count=0, mode latch=000, all outputs 0.
//  - States: IDLE, SPRINKLE, DRIP, HOLDOFF, ABORT. Outputs decoded from next state, registered,
//    so valves change on the same edge as the state transition.
//  - IDLE: irr_type latched into mode reg at start. Valid non-zero code and water_ok=1 ->
//    001/100 -> SPRINKLE, 010 -> DRIP; count cleared. water_ok=0 or 000 or invalid code -> stay.
//  - SPRINKLE: sprinkler_valve=1. Each tick increments count; tick with count==SPRINKLE_TICKS-1
//    -> mode 001: DRIP (count cleared, valves swap same edge, no gap/overlap); mode 100: HOLDOFF.
//  - DRIP: drip_valve=1. Tick with count==DRIP_TICKS-1 -> HOLDOFF.
//  - Phase length = exactly N tick pulses after entry; ticks coincident with entry edge not counted.
//  - Entry to HOLDOFF from normal completion: done=1 for one cycle. HOLDOFF: valves off; stay until
//    irr_type==000, then IDLE. Prevents back-to-back re-watering on a stuck code.
//  - water_ok=0 in SPRINKLE or DRIP (priority over tick expiry same cycle) -> ABORT: valves off,
//    fault=1, no done. ABORT -> IDLE when irr_type==000 and water_ok=1.
//  - irr_type changes during SPRINKLE/DRIP ignored; latched mode governs the whole cycle.
//  - tick ignored outside SPRINKLE/DRIP; count never wraps (cleared on every phase entry).
//  - rst_n asserted mid-cycle: valves close immediately (async), return to IDLE.
// STRUCTURE
//  - irrigation_pkg: type codes (IRR_NONE=000, IRR_SPR_DRIP=001, IRR_DRIP=010, IRR_SPR=100),
//    state encoding localparams.
//  - Sub-module irrigation_tick_counter: CNT_W counter with clear, tick-enable, terminal-count
//    compare against a runtime limit input; FSM + output regs live in irrigation_sequencer.
// TESTING (SPRINKLE_TICKS=3, DRIP_TICKS=2)
//  - irr_type=100, water_ok=1 -> sprinkler_valve=1 next edge; after 3rd tick off, done pulse, HOLDOFF;
//    irr_type=000 -> IDLE.
//  - irr_type=001 -> sprinkler 3 ticks, then drip_valve=1 on same edge sprinkler drops, 2 ticks, done=1.
//  - irr_type=010 held at 010 after done -> stays HOLDOFF, no restart, valves 0 for 20 ticks.
//  - irr_type=001, water_ok drops after 1 tick -> valves 0, fault=1, no done; water_ok=1 and
//    irr_type=000 -> fault=0, IDLE.
//  - irr_type=110 -> bad_code=1, valves stay 0; irr_type=011 with water_ok=0 -> no start.
//  - rst_n=0 mid-DRIP -> drip_valve=0 asynchronously, all outputs 0; release -> IDLE.

Source files
------------

// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - irrigation type codes, sequencer states and code classifiers
// Contents:
//   IRR_*          3-bit irrigation type codes produced by irrigation_state
//   state_t        sequencer FSM state encoding
//   is_start_code  1 for a code that starts a cycle (001, 010, 100)
//   is_bad_code    1 for a non-zero code that is not a start code
package irrigation_pkg;

    localparam logic [2:0] IRR_NONE     = 3'b000;
    localparam logic [2:0] IRR_SPR_DRIP = 3'b001;
    localparam logic [2:0] IRR_DRIP     = 3'b010;
    localparam logic [2:0] IRR_SPR      = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPRINKLE = 3'd1,
        ST_DRIP     = 3'd2,
        ST_HOLDOFF  = 3'd3,
        ST_ABORT    = 3'd4
    } state_t;

    function automatic logic is_start_code(input logic [2:0] code);
        return (code == IRR_SPR_DRIP) || (code == IRR_DRIP) || (code == IRR_SPR);
    endfunction

    function automatic logic is_bad_code(input logic [2:0] code);
        return (code != IRR_NONE) && !is_start_code(code);
    endfunction

endpackage

// File: rtl/irrigation_sequencer_if.sv
// rtl/irrigation_sequencer_if.sv - sequencer control/status bundle
// Signals:
//   tick, irr_type[2:0], water_ok                       control inputs to the sequencer
//   sprinkler_valve, drip_valve, busy, done, fault,
//   bad_code                                             registered status outputs
// Modports: master drives the controls, slave is the sequencer.
interface irrigation_sequencer_if;

    logic       tick;
    logic [2:0] irr_type;
    logic       water_ok;
    logic       sprinkler_valve;
    logic       drip_valve;
    logic       busy;
    logic       done;
    logic       fault;
    logic       bad_code;

    modport master (
        output tick, irr_type, water_ok,
        input  sprinkler_valve, drip_valve, busy, done, fault, bad_code
    );

    modport slave (
        input  tick, irr_type, water_ok,
        output sprinkler_valve, drip_valve, busy, done, fault, bad_code
    );

endinterface

// File: rtl/irrigation_tick_counter.sv
// rtl/irrigation_tick_counter.sv - phase tick counter with clear and terminal-count compare
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear, wins over tick_en
//   tick_en      count one tick this cycle
//   limit        terminal value (phase length minus one)
//   terminal     1 when the tick of this cycle is the last one of the phase
module irrigation_tick_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             tick_en,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick_en) begin
            count <= count + 1'b1;
        end
    end

    // The owner leaves the phase on terminal, so the count never runs past limit.
    assign terminal = tick_en && (count == limit);

endmodule

// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - timed sprinkler/drip irrigation cycle sequencer
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  tick, irr_type, water_ok in; sprinkler_valve, drip_valve, busy,
//                done, fault, bad_code out (all outputs registered)
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int SPRINKLE_TICKS = 1350,
    parameter int DRIP_TICKS     = 1800,
    parameter int CNT_W          = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    irrigation_sequencer_if.slave  bus
);

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       mode_q;
    logic             in_phase;
    logic             tick_en;
    logic             clr;
    logic             terminal;
    logic             done_d;
    logic [CNT_W-1:0] limit;

    assign in_phase = (state_q == ST_SPRINKLE) || (state_q == ST_DRIP);
    assign tick_en  = bus.tick && in_phase;
    assign limit    = (state_q == ST_SPRINKLE) ? CNT_W'(SPRINKLE_TICKS - 1)
                                               : CNT_W'(DRIP_TICKS - 1);
    // Clearing on every state change restarts the count at each phase entry,
    // including the direct sprinkle->drip hand-over.
    assign clr      = (state_d != state_q);

    irrigation_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .tick_en  (tick_en),
        .limit    (limit),
        .terminal (terminal)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.water_ok && is_start_code(bus.irr_type)) begin
                    state_d = (bus.irr_type == IRR_DRIP) ? ST_DRIP : ST_SPRINKLE;
                end
            end
            ST_SPRINKLE: begin
                // Water loss outranks a phase expiring on the same cycle.
                if (!bus.water_ok) begin
                    state_d = ST_ABORT;
                end else if (terminal) begin
                    if (mode_q == IRR_SPR_DRIP) begin
                        state_d = ST_DRIP;
                    end else begin
                        state_d = ST_HOLDOFF;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DRIP: begin
                if (!bus.water_ok) begin
                    state_d = ST_ABORT;
                end else if (terminal) begin
                    state_d = ST_HOLDOFF;
                    done_d  = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                // Wait for soil-wet so a stuck code cannot re-water back to back.
                if (bus.irr_type == IRR_NONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if ((bus.irr_type == IRR_NONE) && bus.water_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the next state so valves move on the transition edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= ST_IDLE;
            mode_q              <= IRR_NONE;
            bus.sprinkler_valve <= 1'b0;
            bus.drip_valve      <= 1'b0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.fault           <= 1'b0;
            bus.bad_code        <= 1'b0;
        end else begin
            state_q <= state_d;
            // Tracking irr_type only while idle freezes the mode for the whole cycle.
            if (state_q == ST_IDLE) begin
                mode_q <= bus.irr_type;
            end
            bus.sprinkler_valve <= (state_d == ST_SPRINKLE);
            bus.drip_valve      <= (state_d == ST_DRIP);
            bus.busy            <= (state_d == ST_SPRINKLE) || (state_d == ST_DRIP);
            bus.done            <= done_d;
            bus.fault           <= (state_d == ST_ABORT);
            bus.bad_code        <= (state_d == ST_IDLE) && is_bad_code(bus.irr_type);
        end
    end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb/tb_irrigation_sequencer.sv - randomized and directed bench for irrigation_sequencer
module tb_irrigation_sequencer;

    localparam int SPR_N  = 3;
    localparam int DRIP_N = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    irrigation_sequencer_if bus();

    irrigation_sequencer #(
        .SPRINKLE_TICKS (SPR_N),
        .DRIP_TICKS     (DRIP_N),
        .CNT_W          (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum int {P_IDLE, P_SPR, P_DRIP, P_HOLD, P_ABORT} phase_t;
    phase_t     m_phase;
    int         m_left;
    logic [2:0] m_mode;
    logic       m_done;
    logic       m_bad;

    logic [5:0] obs;
    logic [5:0] exp;

    // {sprinkler, drip, busy, done, fault, bad_code}
    function automatic logic [5:0] model_out();
        return {m_phase == P_SPR, m_phase == P_DRIP, (m_phase == P_SPR) || (m_phase == P_DRIP),
                m_done, m_phase == P_ABORT, m_bad};
    endfunction

    function automatic logic [5:0] dut_out();
        return {bus.sprinkler_valve, bus.drip_valve, bus.busy, bus.done, bus.fault, bus.bad_code};
    endfunction

    function automatic logic starts(input logic [2:0] code);
        return (code == 3'd1) || (code == 3'd2) || (code == 3'd4);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_mode  = 3'd0;
        m_done  = 1'b0;
        m_bad   = 1'b0;
    endtask

    // One clock of behaviour: phases last a number of remaining tick pulses.
    task automatic model_step(input logic t, input logic [2:0] code, input logic wok);
        m_done = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (wok && starts(code)) begin
                    m_mode = code;
                    if (code == 3'd2) begin
                        m_phase = P_DRIP;
                        m_left  = DRIP_N;
                    end else begin
                        m_phase = P_SPR;
                        m_left  = SPR_N;
                    end
                end
            end
            P_SPR, P_DRIP: begin
                if (!wok) begin
                    m_phase = P_ABORT;
                end else if (t) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_phase == P_SPR && m_mode == 3'd1) begin
                            m_phase = P_DRIP;
                            m_left  = DRIP_N;
                        end else begin
                            m_phase = P_HOLD;
                            m_done  = 1'b1;
                        end
                    end
                end
            end
            P_HOLD: begin
                if (code == 3'd0) m_phase = P_IDLE;
            end
            default: begin
                if (code == 3'd0 && wok) m_phase = P_IDLE;
            end
        endcase
        m_bad = (m_phase == P_IDLE) && (code != 3'd0) && !starts(code);
    endtask

    task automatic cycle();
        logic       t;
        logic [2:0] code;
        logic       wok;
        t    = bus.tick;
        code = bus.irr_type;
        wok  = bus.water_ok;
        @(posedge clk);
        model_step(t, code, wok);
        #1;
    endtask

    task automatic test_reset();
        bus.tick     = 1'b0;
        bus.irr_type = 3'd0;
        bus.water_ok = 1'b1;
        rst_n        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_out() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", dut_out(), 6'b000000);
        end
        rst_n = 1'b1;
        cycle();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_sprinkle();
        bus.irr_type = 3'b100;
        bus.water_ok = 1'b1;
        cycle();
        checks++;
        if (bus.sprinkler_valve !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL sprinkle_open: got spr=%b busy=%b expected 1 1", bus.sprinkler_valve, bus.busy);
        end
        for (int i = 0; i < SPR_N; i++) begin
            bus.tick = 1'b1;
            cycle();
            bus.tick = 1'b0;
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sprinkle_tick%0d: got %b expected %b", i, obs, exp);
            end
            cycle();
        end
        checks++;
        if (bus.sprinkler_valve !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL sprinkle_end: got spr=%b done=%b expected 0 0", bus.sprinkler_valve, bus.done);
        end
        bus.irr_type = 3'd0;
        cycle();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sprinkle_rearm: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_spr_drip();
        bus.irr_type = 3'b001;
        bus.tick     = 1'b1;
        cycle();
        for (int i = 0; i < SPR_N + DRIP_N; i++) begin
            bus.tick = 1'b1;
            cycle();
            bus.tick = 1'b0;
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL spr_drip_tick%0d: got %b expected %b", i, obs, exp);
            end
            if (i == SPR_N - 1) begin
                checks++;
                if (obs !== 6'b011000) begin
                    errors++;
                    $display("FAIL spr_drip_swap: got %b expected %b", obs, 6'b011000);
                end
            end
            if (i == SPR_N + DRIP_N - 1) begin
                checks++;
                if (obs !== 6'b000100) begin
                    errors++;
                    $display("FAIL spr_drip_done: got %b expected %b", obs, 6'b000100);
                end
            end
        end
        bus.irr_type = 3'd0;
        cycle();
        cycle();
    endtask

    task automatic test_holdoff_stuck();
        bus.irr_type = 3'b010;
        cycle();
        for (int i = 0; i < DRIP_N + 20; i++) begin
            bus.tick = 1'b1;
            cycle();
            bus.tick = 1'b0;
            cycle();
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL holdoff_tick%0d: got %b expected %b", i, obs, exp);
            end
        end
        checks++;
        if (bus.drip_valve !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_stuck: got drip=%b busy=%b expected 0 0", bus.drip_valve, bus.busy);
        end
        bus.irr_type = 3'd0;
        cycle();
    endtask

    task automatic test_abort();
        bus.irr_type = 3'b001;
        cycle();
        bus.tick = 1'b1;
        cycle();
        bus.tick     = 1'b0;
        bus.water_ok = 1'b0;
        cycle();
        checks++;
        if (dut_out() !== 6'b000010) begin
            errors++;
            $display("FAIL abort_enter: got %b expected %b", dut_out(), 6'b000010);
        end
        bus.water_ok = 1'b1;
        cycle();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL abort_hold: got %b expected %b", obs, exp);
        end
        bus.irr_type = 3'd0;
        cycle();
        checks++;
        if (dut_out() !== 6'b000000) begin
            errors++;
            $display("FAIL abort_exit: got %b expected %b", dut_out(), 6'b000000);
        end
        // Water lost on the final drip tick: abort wins, no done.
        bus.irr_type = 3'b010;
        cycle();
        bus.tick = 1'b1;
        cycle();
        bus.water_ok = 1'b0;
        cycle();
        bus.tick = 1'b0;
        checks++;
        if (dut_out() !== 6'b000010) begin
            errors++;
            $display("FAIL abort_priority: got %b expected %b", dut_out(), 6'b000010);
        end
        bus.water_ok = 1'b1;
        bus.irr_type = 3'd0;
        cycle();
    endtask

    task automatic test_bad_code();
        bus.irr_type = 3'b110;
        cycle();
        cycle();
        checks++;
        if (dut_out() !== 6'b000001) begin
            errors++;
            $display("FAIL bad_code_110: got %b expected %b", dut_out(), 6'b000001);
        end
        bus.irr_type = 3'b011;
        bus.water_ok = 1'b0;
        cycle();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL bad_code_011: got %b expected %b", obs, exp);
        end
        bus.irr_type = 3'b001;
        cycle();
        checks++;
        if (dut_out() !== 6'b000000) begin
            errors++;
            $display("FAIL no_water_no_start: got %b expected %b", dut_out(), 6'b000000);
        end
        bus.water_ok = 1'b1;
        bus.irr_type = 3'd0;
        cycle();
    endtask

    task automatic test_async_reset();
        bus.irr_type = 3'b010;
        cycle();
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        checks++;
        if (bus.drip_valve !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got drip=%b expected 1", bus.drip_valve);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_out() !== 6'b000000) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", dut_out(), 6'b000000);
        end
        bus.irr_type = 3'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.irr_type = 3'b100;
        cycle();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL async_restart: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_random();
        logic [2:0] table_codes [10];
        table_codes = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 1500; i++) begin
            bus.tick     = ($urandom_range(0, 2) == 0);
            bus.water_ok = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 9) >= 7) begin
                bus.irr_type = table_codes[$urandom_range(0, 9)];
            end
            cycle();
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sprinkle();
        test_spr_drip();
        test_holdoff_stuck();
        test_abort();
        test_bad_code();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
